cam_capture: RTL

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_addr_gen.sv | 92 +++++++++
 rtl/cam_capture.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: FSM encoding and
// default geometry constants.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    BLANK      = 2'd2,
    LINE       = 2'd3
  } cam_state_e;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_DECIM = 1;

  // Decimation is restricted to powers of two, so division becomes a shift.
  function automatic int decim_shift(input int decim);
    return (decim >= 4) ? 2 : (decim >= 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/cam_addr_gen.sv
// Source pixel/line counting, decimation and bounds test, and incremental
// linear address generation for the capture block.
module cam_addr_gen
  import cam_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int XY_W    = 11,
  parameter int ADDR_W  = 19,
  parameter int DECIM   = DEF_DECIM,
  parameter int Y_PHASE = 1
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              active,
  input  logic              href,
  input  logic              href_rise,
  input  logic              href_fall,
  output logic              accept,
  output logic              ovf_hit,
  output logic [XY_W-1:0]   x_out,
  output logic [XY_W-1:0]   y_out,
  output logic [ADDR_W-1:0] addr
);

  // Extra headroom so oversized lines saturate instead of aliasing back
  // into the visible window.
  localparam int              SRC_W = XY_W + 3;
  localparam int              DSH   = decim_shift(DECIM);
  localparam logic [SRC_W-1:0] DMASK = SRC_W'(DECIM - 1);
  localparam logic            Y_SEL = (Y_PHASE != 0);

  logic [SRC_W-1:0]  src_x;
  logic [SRC_W-1:0]  src_y;
  logic [SRC_W-1:0]  cur_x;
  logic [SRC_W-1:0]  dx;
  logic [SRC_W-1:0]  dy;
  logic [ADDR_W-1:0] line_base;
  logic              phase;
  logic              cur_phase;
  logic              is_y;
  logic              on_grid;
  logic              in_bounds;

  // The first byte of a line sees the cleared column and phase.
  assign cur_x     = href_rise ? '0 : src_x;
  assign cur_phase = href_rise ? 1'b0 : phase;
  assign is_y      = active && href && (cur_phase == Y_SEL);

  assign dx        = cur_x >> DSH;
  assign dy        = src_y >> DSH;
  assign on_grid   = ((cur_x & DMASK) == '0) && ((src_y & DMASK) == '0);
  assign in_bounds = (dx < SRC_W'(IMG_W)) && (dy < SRC_W'(IMG_H));

  assign accept    = is_y && on_grid && in_bounds;
  assign ovf_hit   = is_y && on_grid && !in_bounds;
  assign x_out     = dx[XY_W-1:0];
  assign y_out     = dy[XY_W-1:0];
  assign addr      = line_base + ADDR_W'(dx);

  // line_base tracks y_out*IMG_W by adding IMG_W whenever y_out advances.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      src_x     <= '0;
      src_y     <= '0;
      phase     <= 1'b0;
      line_base <= '0;
    end else if (clear) begin
      src_x     <= '0;
      src_y     <= '0;
      phase     <= 1'b0;
      line_base <= '0;
    end else if (active) begin
      if (href) begin
        phase <= ~cur_phase;
        if (is_y)
          src_x <= (cur_x == '1) ? cur_x : cur_x + 1'b1;
        else if (href_rise)
          src_x <= '0;
      end else if (href_fall) begin
        phase <= 1'b0;
        if (src_y != '1) begin
          src_y <= src_y + 1'b1;
          if (((src_y + 1'b1) & DMASK) == '0)
            line_base <= line_base + ADDR_W'(IMG_W);
        end
      end
    end
  end

endmodule

// File: rtl/cam_capture.sv
// Camera capture front end: frame FSM, vsync/href edge detection and the
// registered pixel write interface.
module cam_capture
  import cam_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int XY_W    = 11,
  parameter int ADDR_W  = 19,
  parameter int DECIM   = DEF_DECIM,
  parameter int Y_PHASE = 1,
  parameter int VS_ACT  = 0,
  parameter int BORDER  = 1
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic [7:0]        value,
  output logic [XY_W-1:0]   x_addr,
  output logic [XY_W-1:0]   y_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              is_val,
  output logic              frame_start,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              ovf
);

  localparam logic VS_LVL = (VS_ACT != 0);

  cam_state_e        state_q;
  cam_state_e        state_d;
  logic              vs_blank;
  logic              vs_blank_q;
  logic              href_q;
  logic              href_rise;
  logic              href_fall;
  logic              start_det;
  logic              end_det;
  logic              active;
  logic              accept;
  logic              ovf_hit;
  logic              is_border;
  logic [XY_W-1:0]   x_cur;
  logic [XY_W-1:0]   y_cur;
  logic [ADDR_W-1:0] addr_cur;

  assign vs_blank  = (vsync == VS_LVL);
  assign href_rise = href && !href_q;
  assign href_fall = !href && href_q;
  // Blanking in the same cycle as a byte ends the frame first; the byte is lost.
  assign active    = (state_q == LINE) && !vs_blank;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      vs_blank_q <= 1'b0;
      href_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_blank_q <= vs_blank;
      href_q     <= href;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns each output; no latches.
    state_d   = state_q;
    start_det = 1'b0;
    end_det   = 1'b0;
    case (state_q)
      IDLE:       if (enable) state_d = WAIT_BLANK;
      WAIT_BLANK: if (vs_blank) state_d = BLANK;
      BLANK: begin
        // Only a genuine blanking-to-active edge starts a frame.
        if (vs_blank_q && !vs_blank) begin
          if (enable) begin
            state_d   = LINE;
            start_det = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LINE: begin
        if (vs_blank) begin
          state_d = BLANK;
          end_det = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  cam_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .XY_W    (XY_W),
    .ADDR_W  (ADDR_W),
    .DECIM   (DECIM),
    .Y_PHASE (Y_PHASE)
  ) u_addr_gen (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clear     (start_det),
    .active    (active),
    .href      (href),
    .href_rise (href_rise),
    .href_fall (href_fall),
    .accept    (accept),
    .ovf_hit   (ovf_hit),
    .x_out     (x_cur),
    .y_out     (y_cur),
    .addr      (addr_cur)
  );

  assign is_border = (BORDER != 0) &&
                     ((x_cur == '0) || (x_cur == XY_W'(IMG_W - 1)) ||
                      (y_cur == '0) || (y_cur == XY_W'(IMG_H - 1)));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      value       <= '0;
      x_addr      <= '0;
      y_addr      <= '0;
      mem_addr    <= '0;
      is_val      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      ovf         <= 1'b0;
    end else begin
      // NOTE: registered state is updated with non-blocking assignments only.
      frame_start <= start_det;
      frame_done  <= end_det;
      is_val      <= accept;
      if (end_det)
        frame_cnt <= frame_cnt + 16'd1;
      if (start_det) begin
        ovf      <= 1'b0;
        mem_addr <= '0;
      end else begin
        if (ovf_hit)
          ovf <= 1'b1;
        if (accept) begin
          value    <= is_border ? 8'hFF : data;
          x_addr   <= x_cur;
          y_addr   <= y_cur;
          mem_addr <= addr_cur;
        end
      end
    end
  end

endmodule
